// File: rtl/trena_scheduler.sv
// Measurement scheduler for the trena unit: single-shot and periodic measurements with timeout,
// plus optional retry-after-timeout enabled by defining TRENA_SCHED_RETRY_EN.
module trena_scheduler #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int GAP_CYCLES     = 5000000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       modo_continuo,
    input  logic       unico,
    input  logic       pronto_medida,
    output logic       mensurar,
    output logic       zera_trena,
    output logic       medida_ok,
    output logic       medida_erro,
    output logic       ocupado,
    output logic [7:0] n_medidas,
    output logic [3:0] n_falhas,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        DISPARA   = 3'b001,
        ESPERA    = 3'b010,
        FALHA     = 3'b011,
        CONCLUI   = 3'b100,
        INTERVALO = 3'b101
    } state_t;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   timeout_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            timeout_hit;
    logic            gap_done;
    logic            final_fail;

    assign timeout_hit = (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign gap_done    = (gap_cnt == GW'(GAP_CYCLES - 1));

`ifdef TRENA_SCHED_RETRY_EN
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    logic [RW-1:0] retry_cnt;

    assign final_fail = (int'(retry_cnt) >= MAX_RETRIES);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retry_cnt <= '0;
        end else if (state == FALHA) begin
            retry_cnt <= final_fail ? '0 : retry_cnt + RW'(1);
        end else if (state == CONCLUI) begin
            retry_cnt <= '0;
        end
    end
`else
    // Every timeout is final in this build; the retry limit has no effect.
    assign final_fail = 1'b1 | (MAX_RETRIES < 0);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (modo_continuo || unico) state_next = DISPARA;
            DISPARA:   state_next = ESPERA;
            ESPERA: begin
                if (pronto_medida)    state_next = CONCLUI;
                else if (timeout_hit) state_next = FALHA;
            end
            FALHA: begin
                if (!final_fail)        state_next = DISPARA;
                else if (modo_continuo) state_next = INTERVALO;
                else                    state_next = IDLE;
            end
            CONCLUI:   state_next = modo_continuo ? INTERVALO : IDLE;
            INTERVALO: begin
                if (!modo_continuo) state_next = IDLE;
                else if (gap_done)  state_next = DISPARA;
            end
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        mensurar    = (state == DISPARA);
        zera_trena  = (state == FALHA);
        medida_ok   = (state == CONCLUI);
        medida_erro = (state == FALHA) && final_fail;
        ocupado     = (state != IDLE);
        db_estado   = state;
    end

    // Both counters restart from zero on every entry into their state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_cnt <= '0;
            gap_cnt     <= '0;
        end else begin
            timeout_cnt <= (state == ESPERA) ? timeout_cnt + TW'(1) : '0;
            gap_cnt     <= (state == INTERVALO) ? gap_cnt + GW'(1) : '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            n_medidas <= 8'd0;
            n_falhas  <= 4'd0;
        end else begin
            if (state == CONCLUI) n_medidas <= n_medidas + 8'd1;
            if ((state == FALHA) && final_fail && (n_falhas != 4'hF)) n_falhas <= n_falhas + 4'd1;
        end
    end

endmodule

// File: tb/tb_trena_scheduler.sv
// Directed self-checking bench for trena_scheduler (TIMEOUT=20, GAP=10, MAX_RETRIES=2).
module tb_trena_scheduler;

    localparam int TIMEOUT = 20;
    localparam int GAP     = 10;
    localparam int MAXR    = 2;
`ifdef TRENA_SCHED_RETRY_EN
    localparam int ATTEMPTS = MAXR + 1;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       modo_continuo = 1'b0;
    logic       unico = 1'b0;
    logic       pronto_medida;
    logic       mensurar, zera_trena, medida_ok, medida_erro, ocupado;
    logic [7:0] n_medidas;
    logic [3:0] n_falhas;
    logic [2:0] db_estado;

    int checks = 0;
    int fails  = 0;

    int cyc = 0, last_mens = -1, period = 0;
    int n_mens = 0, n_zera = 0, n_ok = 0, n_erro = 0;
    bit resp_en = 1'b0;
    int resp_delay = 3, resp_left = 0;
    bit pronto_force = 1'b0;

    trena_scheduler #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .GAP_CYCLES    (GAP),
        .MAX_RETRIES   (MAXR)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .modo_continuo(modo_continuo),
        .unico        (unico),
        .pronto_medida(pronto_medida),
        .mensurar     (mensurar),
        .zera_trena   (zera_trena),
        .medida_ok    (medida_ok),
        .medida_erro  (medida_erro),
        .ocupado      (ocupado),
        .n_medidas    (n_medidas),
        .n_falhas     (n_falhas),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    // Trena unit model and pulse monitor: answers resp_delay cycles after each mensurar.
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            resp_left     <= 0;
            pronto_medida <= 1'b0;
        end else begin
            pronto_medida <= pronto_force || (resp_left == 1);
            if (mensurar && resp_en) resp_left <= resp_delay;
            else if (resp_left > 0)  resp_left <= resp_left - 1;
            if (mensurar) begin
                n_mens <= n_mens + 1;
                if (last_mens >= 0) period <= cyc - last_mens;
                last_mens <= cyc;
            end
            if (zera_trena)  n_zera <= n_zera + 1;
            if (medida_ok)   n_ok   <= n_ok + 1;
            if (medida_erro) n_erro <= n_erro + 1;
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_counts();
        n_mens = 0; n_zera = 0; n_ok = 0; n_erro = 0; last_mens = -1; period = 0;
    endtask

    task automatic pulse_unico();
        unico = 1'b1;
        step();
        unico = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (ocupado === 1'b0) done = 1'b1;
        end
        if (!done) begin
            checks++; fails++;
            $display("FAIL %s: ocupado still %b after %0d cycles, required 0", name, ocupado, budget);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (db_estado === s) done = 1'b1;
        end
        if (!done) begin
            checks++; fails++;
            $display("FAIL %s: db_estado %0d after %0d cycles, required %0d", name, db_estado, budget, s);
        end
    endtask

    task automatic wait_counts(input int mens_t, input int ok_t, input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (n_mens >= mens_t && n_ok >= ok_t) done = 1'b1;
        end
        if (!done) begin
            checks++; fails++;
            $display("FAIL %s: mensurar=%0d ok=%0d, required %0d/%0d", name, n_mens, n_ok, mens_t, ok_t);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++; if (db_estado !== 3'b000) begin fails++; $display("FAIL reset_estado: got %0d required 0", db_estado); end
        checks++; if (ocupado !== 1'b0) begin fails++; $display("FAIL reset_ocupado: got %b required 0", ocupado); end
        checks++; if ({mensurar, zera_trena, medida_ok, medida_erro} !== 4'b0000) begin
            fails++; $display("FAIL reset_pulses: got %b required 0000", {mensurar, zera_trena, medida_ok, medida_erro});
        end
        checks++; if (n_medidas !== 8'd0) begin fails++; $display("FAIL reset_n_medidas: got %0d required 0", n_medidas); end
        checks++; if (n_falhas !== 4'd0) begin fails++; $display("FAIL reset_n_falhas: got %0d required 0", n_falhas); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_unico();
        clear_counts();
        resp_en = 1'b1; resp_delay = 5;
        pulse_unico();
        checks++; if (mensurar !== 1'b1) begin fails++; $display("FAIL unico_latency: mensurar %b required 1", mensurar); end
        checks++; if (db_estado !== 3'b001) begin fails++; $display("FAIL unico_dispara: got %0d required 1", db_estado); end
        step();
        checks++; if (db_estado !== 3'b010 || mensurar !== 1'b0) begin
            fails++; $display("FAIL unico_espera: estado %0d mensurar %b required 2/0", db_estado, mensurar);
        end
        pulse_unico();
        wait_idle(40, "unico_idle");
        checks++; if (n_mens !== 1) begin fails++; $display("FAIL unico_mensurar_count: got %0d required 1", n_mens); end
        checks++; if (n_ok !== 1) begin fails++; $display("FAIL unico_ok_count: got %0d required 1", n_ok); end
        checks++; if (n_medidas !== 8'd1) begin fails++; $display("FAIL unico_n_medidas: got %0d required 1", n_medidas); end
        checks++; if (n_erro !== 0 || n_zera !== 0) begin
            fails++; $display("FAIL unico_no_error: erro %0d zera %0d required 0/0", n_erro, n_zera);
        end
        checks++; if (ocupado !== 1'b0) begin fails++; $display("FAIL unico_ocupado: got %b required 0", ocupado); end
    endtask

    task automatic test_stray_pronto();
        pronto_force = 1'b1;
        step();
        pronto_force = 1'b0;
        repeat (3) step();
        checks++; if (db_estado !== 3'b000 || n_medidas !== 8'd1) begin
            fails++; $display("FAIL stray_pronto: estado %0d n_medidas %0d required 0/1", db_estado, n_medidas);
        end
    endtask

    task automatic test_continuous();
        clear_counts();
        resp_en = 1'b1; resp_delay = 3;
        modo_continuo = 1'b1;
        wait_counts(4, 0, 120, "cont_loops");
        checks++; if (period !== 15) begin fails++; $display("FAIL cont_period: got %0d required 15", period); end
        wait_state(3'b101, 40, "cont_intervalo");
        checks++; if (n_ok !== 4) begin fails++; $display("FAIL cont_ok_count: got %0d required 4", n_ok); end
        checks++; if (n_medidas !== 8'd5) begin fails++; $display("FAIL cont_n_medidas: got %0d required 5", n_medidas); end
        modo_continuo = 1'b0;
        step();
        checks++; if (db_estado !== 3'b000 || ocupado !== 1'b0) begin
            fails++; $display("FAIL cont_stop: estado %0d ocupado %b required 0/0", db_estado, ocupado);
        end
        repeat (20) step();
        checks++; if (n_mens !== 4) begin fails++; $display("FAIL cont_no_restart: got %0d required 4", n_mens); end
    endtask

    task automatic test_timeout_fail();
        clear_counts();
        resp_en = 1'b0;
        pulse_unico();
        wait_idle(100, "timeout_idle");
        checks++; if (n_mens !== ATTEMPTS) begin fails++; $display("FAIL timeout_mensurar: got %0d required %0d", n_mens, ATTEMPTS); end
        checks++; if (n_zera !== ATTEMPTS) begin fails++; $display("FAIL timeout_zera: got %0d required %0d", n_zera, ATTEMPTS); end
        checks++; if (n_erro !== 1 || n_ok !== 0) begin
            fails++; $display("FAIL timeout_erro: erro %0d ok %0d required 1/0", n_erro, n_ok);
        end
        checks++; if (n_falhas !== 4'd1) begin fails++; $display("FAIL timeout_n_falhas: got %0d required 1", n_falhas); end
    endtask

    task automatic test_exact_timeout();
        clear_counts();
        resp_en = 1'b1; resp_delay = TIMEOUT;
        pulse_unico();
        wait_idle(60, "edge_idle");
        checks++; if (n_ok !== 1 || n_zera !== 0 || n_erro !== 0) begin
            fails++; $display("FAIL edge_pronto_wins: ok %0d zera %0d erro %0d required 1/0/0", n_ok, n_zera, n_erro);
        end
        clear_counts();
        resp_delay = TIMEOUT + 1;
        pulse_unico();
        wait_idle(100, "late_idle");
        checks++; if (n_ok !== 0 || n_erro !== 1 || n_zera !== ATTEMPTS) begin
            fails++; $display("FAIL late_pronto: ok %0d erro %0d zera %0d required 0/1/%0d", n_ok, n_erro, n_zera, ATTEMPTS);
        end
        checks++; if (n_falhas !== 4'd2) begin fails++; $display("FAIL late_n_falhas: got %0d required 2", n_falhas); end
    endtask

    task automatic test_saturation();
        resp_en = 1'b0;
        for (int k = 0; k < 13; k++) begin
            pulse_unico();
            wait_idle(100, "sat_idle");
        end
        checks++; if (n_falhas !== 4'd15) begin fails++; $display("FAIL sat_reach_15: got %0d required 15", n_falhas); end
        for (int k = 0; k < 2; k++) begin
            pulse_unico();
            wait_idle(100, "sat_idle");
        end
        checks++; if (n_falhas !== 4'd15) begin fails++; $display("FAIL sat_hold_15: got %0d required 15", n_falhas); end
    endtask

    task automatic test_reset_mid();
        resp_en = 1'b0;
        pulse_unico();
        repeat (4) step();
        checks++; if (db_estado !== 3'b010) begin fails++; $display("FAIL rmid_in_espera: got %0d required 2", db_estado); end
        #2 reset = 1'b1;
        #1;
        checks++; if (db_estado !== 3'b000 || ocupado !== 1'b0) begin
            fails++; $display("FAIL rmid_async: estado %0d ocupado %b required 0/0", db_estado, ocupado);
        end
        checks++; if ({mensurar, zera_trena, medida_ok, medida_erro} !== 4'b0000) begin
            fails++; $display("FAIL rmid_pulses: got %b required 0000", {mensurar, zera_trena, medida_ok, medida_erro});
        end
        checks++; if (n_medidas !== 8'd0 || n_falhas !== 4'd0) begin
            fails++; $display("FAIL rmid_counters: medidas %0d falhas %0d required 0/0", n_medidas, n_falhas);
        end
        clear_counts();
        repeat (3) step();
        reset = 1'b0;
        repeat (40) step();
        checks++; if (n_mens !== 0 || n_zera !== 0 || n_ok !== 0 || n_erro !== 0 || db_estado !== 3'b000) begin
            fails++; $display("FAIL rmid_abandoned: mens %0d zera %0d ok %0d erro %0d estado %0d required all 0",
                              n_mens, n_zera, n_ok, n_erro, db_estado);
        end
    endtask

    task automatic test_wrap();
        clear_counts();
        resp_en = 1'b1; resp_delay = 1;
        modo_continuo = 1'b1;
        wait_counts(0, 255, 4000, "wrap_255");
        wait_state(3'b101, 20, "wrap_int_255");
        checks++; if (n_medidas !== 8'd255) begin fails++; $display("FAIL wrap_255: got %0d required 255", n_medidas); end
        wait_counts(0, 256, 40, "wrap_256");
        wait_state(3'b101, 20, "wrap_int_256");
        checks++; if (n_medidas !== 8'd0) begin fails++; $display("FAIL wrap_to_0: got %0d required 0", n_medidas); end
        modo_continuo = 1'b0;
        step();
        checks++; if (db_estado !== 3'b000) begin fails++; $display("FAIL wrap_stop: got %0d required 0", db_estado); end
    endtask

    initial begin
        test_reset();
        test_unico();
        test_stray_pronto();
        test_continuous();
        test_timeout_fail();
        test_exact_timeout();
        test_saturation();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
